dmem_access_ctrl: RTL and testbench

Load/store sequencer between the pipeline MEM stage and the word-wide, single-port, synchronous data memory. It takes one byte-addressed RV32 load/store per request and decodes funct3. It performs lane extraction and sign/zero extension for loads, and read-modify-write sequences for SB/SH. Misaligned, illegal and out-of-range accesses are rejected without touching memory. Request and response use a valid/ready handshake so the pipeline can stall on multi-cycle operations.

---
 rtl/dmem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide single-port synchronous data memory.
// Handles lane extraction and extension for loads, and read-modify-write for sub-word stores.
module dmem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, RMW_WR} state_t;

  state_t            state, state_nxt;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       merge_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic              accept, req_err, size_half, size_word, go;
  logic              re, we;
  logic [31:0]       merged, loaded;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  // Request decode; funct3[1:0] gives the access size for both loads and stores.
  assign accept    = req_valid_i && (state == IDLE);
  assign size_half = (req_funct3_i[1:0] == 2'b01);
  assign size_word = (req_funct3_i[1:0] == 2'b10);
  assign req_err   = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                     (req_funct3_i == 3'b111) ||
                     (size_half && req_addr_i[0]) ||
                     (size_word && (req_addr_i[1:0] != 2'b00)) ||
                     (|req_addr_i[31:ADDR_W+2]);
  assign go        = accept && !req_err;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    mem_addr_o  = waddr_q;
    mem_wdata_o = merge_q;
    re          = 1'b0;
    we          = 1'b0;
    case (state)
      IDLE: begin
        mem_addr_o  = req_addr_i[ADDR_W+1:2];
        mem_wdata_o = req_wdata_i;
        if (go) begin
          if (req_write_i && size_word) begin
            we = 1'b1;
          end else begin
            re        = 1'b1;
            state_nxt = req_write_i ? RMW_RD : LOAD;
          end
        end
      end
      LOAD:    state_nxt = IDLE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR: begin
        we        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated so nothing reaches the memory while reset is held.
  assign mem_re_o    = re && reset_i;
  assign mem_we_o    = we && reset_i;
  assign req_ready_o = (state == IDLE);

  always_comb begin
    merged = mem_rdata_i;
    if (f3_q[1:0] == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  assign lane_b = mem_rdata_i[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  loaded = {{24{lane_b[7]}}, lane_b};
      3'b100:  loaded = {24'h0, lane_b};
      3'b001:  loaded = {{16{lane_h[15]}}, lane_h};
      3'b101:  loaded = {16'h0, lane_h};
      default: loaded = mem_rdata_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[1:0];
            waddr_q <= req_addr_i[ADDR_W+1:2];
            wdata_q <= req_wdata_i[15:0];
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_write_i && size_word) begin
              rsp_valid_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= loaded;
        end
        RMW_RD:  merge_q <= merged;
        RMW_WR:  rsp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a timeline model of responses and memory strobes checked every
// cycle, plus directed requests with hand-computed literal results.
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_write_i = 1'b0;
  logic [2:0]        req_funct3_i = '0;
  logic [31:0]       req_addr_i = '0;
  logic [31:0]       req_wdata_i = '0;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_re_o;
  logic              mem_we_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Environment memory driven by the DUT strobes.
  logic [31:0] env_mem [DEPTH];
  logic [31:0] rd_q = '0;
  assign mem_rdata_i = rd_q;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_re_o) rd_q <= env_mem[mem_addr_o];
    if (mem_we_o) env_mem[mem_addr_o] <= mem_wdata_o;
  end

  // Model state: expected events per cycle number.
  logic [31:0]       ref_mem [DEPTH];
  bit                exp_rsp [int];
  logic              exp_err [int];
  logic [31:0]       exp_rdata [int];
  logic [ADDR_W-1:0] exp_re_addr [int];
  logic [ADDR_W-1:0] exp_we_addr [int];
  logic [31:0]       exp_we_data [int];
  int                busy_until = 0;

  // Observation logs for the literal checks.
  bit          log_v [int];
  logic        log_err [int];
  logic [31:0] log_rdata [int];
  logic [31:0] log_re [int];
  logic [31:0] log_we [int];
  logic        log_ready [int];
  int          rsp_count = 0;
  int          we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_err(input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return !legal || ((addr % size_of(f3)) != 0) || (addr >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] word,
                                             input int off);
    logic [31:0] raw;
    raw = word >> (8 * off);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd4:    return {24'h0, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd5:    return {16'h0, raw[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input int off, input int sz);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
    return w;
  endfunction

  task automatic accept_model();
    int t, idx, off, sz;
    t   = cyc;
    sz  = size_of(req_funct3_i);
    off = int'(req_addr_i[1:0]);
    idx = int'(req_addr_i >> 2);
    if (is_err(req_funct3_i, req_addr_i)) begin
      exp_rsp[t+1] = 1; exp_err[t+1] = 1'b1; exp_rdata[t+1] = '0;
      busy_until = t + 1;
    end else if (req_write_i && sz == 4) begin
      exp_we_addr[t] = ADDR_W'(idx); exp_we_data[t] = req_wdata_i;
      exp_rsp[t+1] = 1; exp_err[t+1] = 1'b0; exp_rdata[t+1] = '0;
      busy_until = t + 1;
    end else if (!req_write_i) begin
      exp_re_addr[t] = ADDR_W'(idx);
      exp_rsp[t+2] = 1; exp_err[t+2] = 1'b0;
      exp_rdata[t+2] = load_value(req_funct3_i, ref_mem[idx], off);
      busy_until = t + 2;
    end else begin
      exp_re_addr[t] = ADDR_W'(idx);
      exp_we_addr[t+2] = ADDR_W'(idx);
      exp_we_data[t+2] = store_merge(ref_mem[idx], req_wdata_i, off, sz);
      exp_rsp[t+3] = 1; exp_err[t+3] = 1'b0; exp_rdata[t+3] = '0;
      busy_until = t + 3;
    end
  endtask

  task automatic compare_cycle();
    int t;
    t = cyc;
    log_ready[t] = req_ready_o;
    if (mem_re_o) log_re[t] = 32'(mem_addr_o);
    if (mem_we_o) begin
      we_count++;
      log_we[t] = mem_wdata_o;
    end
    if (!reset_i) begin
      check("reset_rsp_valid", 32'(rsp_valid_o), 0);
      check("reset_rsp_err", 32'(rsp_err_o), 0);
      check("reset_rsp_rdata", rsp_rdata_o, 0);
      check("reset_mem_re", 32'(mem_re_o), 0);
      check("reset_mem_we", 32'(mem_we_o), 0);
      exp_rsp.delete(); exp_err.delete(); exp_rdata.delete();
      exp_re_addr.delete(); exp_we_addr.delete(); exp_we_data.delete();
      busy_until = 0;
      return;
    end
    check("req_ready", 32'(req_ready_o), 32'(t >= busy_until));
    if (req_valid_i && t >= busy_until) accept_model();
    if (rsp_valid_o) begin
      rsp_count++;
      log_v[t] = 1; log_err[t] = rsp_err_o; log_rdata[t] = rsp_rdata_o;
    end
    check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp.exists(t)));
    if (rsp_valid_o && exp_rsp.exists(t)) begin
      check("rsp_err", 32'(rsp_err_o), 32'(exp_err[t]));
      check("rsp_rdata", rsp_rdata_o, exp_rdata[t]);
    end
    check("mem_re", 32'(mem_re_o), 32'(exp_re_addr.exists(t)));
    if (mem_re_o && exp_re_addr.exists(t)) check("mem_re_addr", 32'(mem_addr_o), 32'(exp_re_addr[t]));
    check("mem_we", 32'(mem_we_o), 32'(exp_we_addr.exists(t)));
    if (exp_we_addr.exists(t)) begin
      if (mem_we_o) begin
        check("mem_we_addr", 32'(mem_addr_o), 32'(exp_we_addr[t]));
        check("mem_we_data", mem_wdata_o, exp_we_data[t]);
      end
      ref_mem[exp_we_addr[t]] = exp_we_data[t];
    end
    exp_rsp.delete(t); exp_err.delete(t); exp_rdata.delete(t);
    exp_re_addr.delete(t); exp_we_addr.delete(t); exp_we_data.delete(t);
  endtask

  always @(negedge clk_i) compare_cycle();

  function automatic logic [31:0] got_re(input int t);
    return log_re.exists(t) ? log_re[t] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] got_we(input int t);
    return log_we.exists(t) ? log_we[t] : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) return;
      @(posedge clk_i); #1;
    end
    check("ready_timeout", 32'(req_ready_o), 1);
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid_i = 1'b1; req_write_i = w; req_funct3_i = f3; req_addr_i = a; req_wdata_i = d;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int t_acc);
    wait_ready();
    drive(w, f3, a, d);
    t_acc = cyc;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input int t, input logic err,
                            input logic [31:0] data);
    if (cyc <= t) begin
      while (cyc <= t) @(posedge clk_i);
      #1;
    end
    check({name, "_present"}, 32'(log_v.exists(t)), 1);
    if (log_v.exists(t)) begin
      check({name, "_err"}, 32'(log_err[t]), 32'(err));
      check({name, "_rdata"}, log_rdata[t], data);
    end
  endtask

  task automatic error_case(input string name, input logic w, input logic [2:0] f3,
                            input logic [31:0] a);
    int t;
    issue(w, f3, a, 32'h0, t);
    expect_rsp(name, t + 1, 1'b1, 32'h0);
    check({name, "_no_re"}, 32'(log_re.exists(t)), 0);
    check({name, "_no_we"}, 32'(log_we.exists(t)), 0);
  endtask

  initial begin
    int t, t2, rc0, wc0;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = env_mem[i];
    end
    env_mem[1] = 32'h8899_AABB;   ref_mem[1] = 32'h8899_AABB;
    env_mem[255] = 32'h0BAD_F00D; ref_mem[255] = 32'h0BAD_F00D;

    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;
    check("ready_after_reset", 32'(req_ready_o), 1);
    @(posedge clk_i); #1;

    issue(1'b0, 3'b000, 32'h005, 32'h0, t); expect_rsp("lb_005", t + 2, 1'b0, 32'hFFFF_FFAA);
    check("lb_re_addr", got_re(t), 32'd1);
    issue(1'b0, 3'b100, 32'h005, 32'h0, t); expect_rsp("lbu_005", t + 2, 1'b0, 32'h0000_00AA);
    issue(1'b0, 3'b001, 32'h006, 32'h0, t); expect_rsp("lh_006", t + 2, 1'b0, 32'hFFFF_8899);
    issue(1'b0, 3'b101, 32'h006, 32'h0, t); expect_rsp("lhu_006", t + 2, 1'b0, 32'h0000_8899);

    // Reset during RMW_RD of SB 0x004 must leave word 1 untouched.
    rc0 = rsp_count; wc0 = we_count;
    issue(1'b1, 3'b000, 32'h004, 32'h0000_0077, t);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    check("ready_after_midop_reset", 32'(req_ready_o), 1);
    repeat (4) @(posedge clk_i); #1;
    check("midop_no_we", 32'(we_count - wc0), 0);
    check("midop_no_rsp", 32'(rsp_count - rc0), 0);
    check("midop_word1", env_mem[1], 32'h8899_AABB);

    issue(1'b1, 3'b000, 32'h006, 32'h1234_5611, t);
    expect_rsp("sb_006", t + 3, 1'b0, 32'h0);
    check("sb_re_addr", got_re(t), 32'd1);
    check("sb_we_data", got_we(t + 2), 32'h8811_AABB);
    check("sb_ready_t1", 32'(log_ready[t+1]), 0);
    check("sb_ready_t2", 32'(log_ready[t+2]), 0);
    check("sb_word1", env_mem[1], 32'h8811_AABB);

    error_case("err_lh_003", 1'b0, 3'b001, 32'h003);
    error_case("err_sw_00a", 1'b1, 3'b010, 32'h00A);
    error_case("err_lw_400", 1'b0, 3'b010, 32'h400);
    error_case("err_f3_011", 1'b0, 3'b011, 32'h000);
    issue(1'b0, 3'b010, 32'h3FC, 32'h0, t); expect_rsp("lw_3fc", t + 2, 1'b0, 32'h0BAD_F00D);

    // SW then LW back to back.
    wait_ready();
    drive(1'b1, 3'b010, 32'h008, 32'hDEAD_BEEF);
    t = cyc;
    @(posedge clk_i); #1;
    drive(1'b0, 3'b010, 32'h008, 32'h0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("sw_we_data", got_we(t), 32'hDEAD_BEEF);
    expect_rsp("sw_008", t + 1, 1'b0, 32'h0);
    expect_rsp("lw_008", t + 3, 1'b0, 32'hDEAD_BEEF);

    // Valid held high across SH then LHU.
    wait_ready();
    rc0 = rsp_count;
    drive(1'b1, 3'b001, 32'h004, 32'h0000_CAFE);
    t = cyc;
    @(posedge clk_i); #1;
    drive(1'b0, 3'b101, 32'h004, 32'h0);
    t2 = -1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_o) begin t2 = cyc; break; end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("held_accept_cycle", 32'(t2), 32'(t + 3));
    expect_rsp("held_sh", t + 3, 1'b0, 32'h0);
    expect_rsp("held_lhu", t + 5, 1'b0, 32'h0000_CAFE);
    repeat (3) @(posedge clk_i); #1;
    check("held_rsp_count", 32'(rsp_count - rc0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
